data_mem_responder: RTL

//  Memory-side responder for CPU load/store traffic: accepts word read/write requests over a
//  req/ready/ack handshake, inserts a programmable number of wait states, and returns read data
//  or write completion. It replaces the zero-latency data memory behind the CPU's data port, so
//  the core can be exercised against realistic memory timing. Local storage is a word array.

---
 rtl/data_mem_responder.sv | 137 +++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// ----------------------------------------------------------------------------
// data_mem_responder
//
// Memory-side responder for CPU load/store traffic. This block sits behind
// the CPU data port in place of a zero-latency data memory. It takes one word
// request at a time over a req/ready handshake and waits LATENCY cycles. It
// then gives a one-cycle ack_o, with read data or an error flag.
//
// Parameters
//   DEPTH    number of 32-bit words stored (byte addresses 0 .. 4*DEPTH-4)
//   LATENCY  wait cycles between accept and ack (0..15)
//
// Ports
//   clk_i    clock; all state changes on the rising edge
//   rst_i    asynchronous reset, active-high; drops any request in flight
//   req_i    request valid from CPU
//   we_i     1 = store word, 0 = load word (sampled at accept)
//   addr_i   byte address (sampled at accept)
//   wdata_i  store data (sampled at accept)
//   ready_o  responder can accept a request this cycle (IDLE only)
//   ack_o    one-cycle completion pulse
//   err_o    with ack_o: request rejected (misaligned or out of range)
//   rdata_o  load data; holds its value until the next load ack
// ----------------------------------------------------------------------------
module data_mem_responder #(
   parameter int DEPTH   = 128,
   parameter int LATENCY = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_i,
   input  logic        we_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        ready_o,
   output logic        ack_o,
   output logic        err_o,
   output logic [31:0] rdata_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t         state;
   logic [CW-1:0]  wait_cnt;
   logic           we_q;
   logic [AW-1:0]  idx_q;
   logic [31:0]    wdata_q;
   logic [31:0]    mem [DEPTH];

   logic           addr_err;
   logic [AW-1:0]  idx_in;

   // A request is rejected when the address is not word-aligned, or when it
   // falls past the last stored word.
   assign addr_err = (addr_i[1:0] != 2'b00) ||
                     ({2'b00, addr_i[31:2]} >= 32'(DEPTH));
   assign idx_in   = addr_i[AW+1:2];

   assign ready_o  = (state == IDLE);

   // NOTE: all state in this block uses non-blocking assignments. Every
   // register then updates from values sampled before the edge, whatever
   // order the statements are in.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= IDLE;
         wait_cnt <= '0;
         we_q     <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         ack_o    <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
         // NOTE: the storage is cleared by reset, so the array is built from
         // flops and not from a RAM macro. A load after reset must return 0.
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (req_i) begin
                  we_q    <= we_i;
                  idx_q   <= idx_in;
                  wdata_q <= wdata_i;
                  if (addr_err) begin
                     // Rejected requests skip the wait states and never touch storage.
                     state <= RESP;
                     ack_o <= 1'b1;
                     err_o <= 1'b1;
                  end else if (LATENCY == 0) begin
                     // With no wait states, the accept edge is also the commit edge.
                     state <= RESP;
                     ack_o <= 1'b1;
                     if (we_i) mem[idx_in] <= wdata_i;
                     else      rdata_o     <= mem[idx_in];
                  end else begin
                     state    <= WAIT;
                     wait_cnt <= CW'(LATENCY - 1);
                  end
               end
            end

            WAIT: begin
               if (wait_cnt == '0) begin
                  state <= RESP;
                  ack_o <= 1'b1;
                  if (we_q) mem[idx_q] <= wdata_q;
                  else      rdata_o    <= mem[idx_q];
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
            end

            RESP: begin
               state <= IDLE;
               ack_o <= 1'b0;
               err_o <= 1'b0;
            end

            default: begin
               state <= IDLE;
               ack_o <= 1'b0;
               err_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
